// File: rtl/spi_xfer_sequencer.sv
// Master-side SPI byte sequencer: takes one byte per handshake, frames it with SS_N,
// clocks it out MSB-first on a divided SCLK and returns the received byte with full/overrun status.
module spi_xfer_sequencer #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              EN,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic [DIV_W-1:0]  CLK_DIV,
    input  logic              TX_VALID,
    input  logic [DATA_W-1:0] TX_DATA,
    output logic              TX_READY,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              RX_FULL,
    input  logic              RX_READ,
    output logic              OVERRUN,
    input  logic              OVR_CLR,
    output logic              BUSY,
    output logic              DONE,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO,
    output logic              SS_N
);

    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_l;
    logic [EW-1:0]     edge_cnt;
    logic              cpol_l;
    logic              cpha_l;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              div_hit;
    logic              sample_edge;
    logic              last_edge;

    assign TX_READY    = EN && (state == IDLE) && !CLR;
    assign BUSY        = (state != IDLE);
    assign div_hit     = (div_cnt == div_l);
    // Even edge index is the leading edge; CPHA selects whether leading edges sample or shift.
    assign sample_edge = (edge_cnt[0] == cpha_l);
    assign last_edge   = (edge_cnt == EW'(EDGES - 1));

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state    <= IDLE;
            SS_N     <= 1'b1;
            SCLK     <= 1'b0;
            MOSI     <= 1'b0;
            RX_DATA  <= '0;
            RX_FULL  <= 1'b0;
            OVERRUN  <= 1'b0;
            DONE     <= 1'b0;
            div_cnt  <= '0;
            div_l    <= '0;
            edge_cnt <= '0;
            cpol_l   <= 1'b0;
            cpha_l   <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
        end else begin
            DONE <= 1'b0;

            // Status reacts to the registered DONE pulse, so RX_READ in the DONE cycle keeps RX_FULL set.
            if (DONE) begin
                RX_FULL <= 1'b1;
                if (RX_FULL && !RX_READ) begin
                    OVERRUN <= 1'b1;
                end else if (OVR_CLR) begin
                    OVERRUN <= 1'b0;
                end
            end else begin
                if (RX_READ) begin
                    RX_FULL <= 1'b0;
                end
                if (OVR_CLR) begin
                    OVERRUN <= 1'b0;
                end
            end

            if (state != IDLE && !EN) begin
                state   <= IDLE;
                SS_N    <= 1'b1;
                SCLK    <= CPOL;
                div_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        SCLK <= CPOL;
                        SS_N <= 1'b1;
                        if (TX_VALID && TX_READY) begin
                            state    <= SETUP;
                            SS_N     <= 1'b0;
                            cpol_l   <= CPOL;
                            cpha_l   <= CPHA;
                            div_l    <= CLK_DIV;
                            div_cnt  <= '0;
                            edge_cnt <= '0;
                            rx_sh    <= '0;
                            if (!CPHA) begin
                                MOSI  <= TX_DATA[DATA_W-1];
                                tx_sh <= {TX_DATA[DATA_W-2:0], 1'b0};
                            end else begin
                                tx_sh <= TX_DATA;
                            end
                        end
                    end
                    SETUP: begin
                        if (div_hit) begin
                            div_cnt <= '0;
                            state   <= XFER;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    XFER: begin
                        if (div_hit) begin
                            div_cnt  <= '0;
                            SCLK     <= ~SCLK;
                            edge_cnt <= edge_cnt + 1'b1;
                            if (sample_edge) begin
                                rx_sh <= {rx_sh[DATA_W-2:0], MISO};
                            end else if (!last_edge) begin
                                MOSI  <= tx_sh[DATA_W-1];
                                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                            end
                            if (last_edge) begin
                                state <= HOLD;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    HOLD: begin
                        SCLK <= cpol_l;
                        if (div_hit) begin
                            div_cnt <= '0;
                            state   <= IDLE;
                            SS_N    <= 1'b1;
                            RX_DATA <= rx_sh;
                            DONE    <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
